// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex display bank: glyph table, blank pattern and
// segment bit positions (bit k of a glyph drives segment a..g for k = 0..6).
package hex_disp_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bits g..a, indexed by nibble value 0..F.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_glyph.sv
// Combinational nibble-to-segment decoder; one instance per display digit.
module hex_glyph
  import hex_disp_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_n
);

  logic [SEG_W-1:0] glyph;

  // Segments are routed by name so a board with a different pin order only
  // has to change the index constants.
  always_comb begin
    glyph        = GLYPH_TABLE[nibble];
    seg_n        = SEG_BLANK;
    seg_n[SEG_A] = glyph[SEG_A];
    seg_n[SEG_B] = glyph[SEG_B];
    seg_n[SEG_C] = glyph[SEG_C];
    seg_n[SEG_D] = glyph[SEG_D];
    seg_n[SEG_E] = glyph[SEG_E];
    seg_n[SEG_F] = glyph[SEG_F];
    seg_n[SEG_G] = glyph[SEG_G];
  end

endmodule

// File: rtl/hex_display_bank.sv
// Bank of seven-segment hex digits with capture, leading-zero blanking and blink.
// Decimal points are driven only when HEX_DISP_DP_EN is defined.
module hex_display_bank
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] seg_n,
  output logic [NUM_DIGITS-1:0]   dp_n
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic [NUM_DIGITS:1]     zero_from;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   blank;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [NUM_DIGITS-1:0]   dp_d;

  // load is a single-cycle strobe with no back-pressure: every edge it is
  // high recaptures the inputs and restarts the blink period in the shown phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q       <= '0;
      mask_q      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (load) begin
      val_q       <= value;
      mask_q      <= blink_mask;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
    end
  end

  // zero_from[i] is high when nibbles i..NUM_DIGITS-1 are all zero.
  assign zero_from[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [SEG_W-1:0] glyph;

    hex_glyph u_glyph (
      .nibble (val_q[4*i +: 4]),
      .seg_n  (glyph)
    );

    if (i == 0) begin : g_lsd
      assign lz_blank[i] = 1'b0;
    end else begin : g_upper
      assign zero_from[i] = zero_from[i+1] & (val_q[4*i +: 4] == 4'h0);
      assign lz_blank[i]  = blank_lz & zero_from[i];
    end

    assign blank[i]         = lz_blank[i] | (mask_q[i] & ~blink_phase);
    assign seg_d[7*i +: 7]  = blank[i] ? SEG_BLANK : glyph;
  end

`ifdef HEX_DISP_DP_EN
  logic [NUM_DIGITS-1:0] dp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q <= '0;
    end else if (load) begin
      dp_q <= dp_in;
    end
  end

  assign dp_d = ~dp_q | blank;
`else
  logic dp_in_unused;

  assign dp_in_unused = ^dp_in;
  assign dp_d         = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= '1;
      dp_n  <= '1;
    end else begin
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed and random bench for hex_display_bank (6 digits, blink half-period 4).
module tb_hex_display_bank;

  localparam int ND = 6;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [23:0]   value = '0;
  logic [5:0]    blink_mask = '0;
  logic [5:0]    dp_in = '0;
  logic          blank_lz = 1'b0;
  logic [41:0]   seg_n;
  logic [5:0]    dp_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [41:0] exp_q[$];
  logic [5:0]  exp_dp_q[$];

  logic [23:0] m_val;
  logic [5:0]  m_mask;
  logic [5:0]  m_dp;
  int          m_cnt;
  logic        m_phase;

  logic [6:0] glyph_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_display_bank #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blink_mask (blink_mask),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .dp_n       (dp_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_digit(input string tag, input int d, input logic [6:0] exp);
    check(tag, 64'(seg_n[7*d +: 7]), 64'(exp));
  endtask

  function automatic void model_out(input logic [23:0] v, input logic [5:0] m,
                                    input logic [5:0] dp, input logic ph, input logic blz,
                                    output logic [41:0] s, output logic [5:0] dn);
    for (int d = 0; d < ND; d++) begin
      logic lz;
      logic blank;
      lz = 1'b0;
      if (blz && d > 0) begin
        lz = 1'b1;
        for (int k = d; k < ND; k++) if (v[4*k +: 4] != 4'h0) lz = 1'b0;
      end
      blank = lz | (m[d] & ~ph);
      s[7*d +: 7] = blank ? 7'h7F : glyph_ref[v[4*d +: 4]];
`ifdef HEX_DISP_DP_EN
      dn[d] = ~dp[d] | blank;
`else
      dn[d] = 1'b1;
`endif
    end
  endfunction

  task automatic model_reset();
    m_val   = '0;
    m_mask  = '0;
    m_dp    = '0;
    m_cnt   = 0;
    m_phase = 1'b1;
  endtask

  // ---------------- driver: one clock edge per call ----------------
  task automatic step(input logic ld, input logic [23:0] v, input logic [5:0] m,
                      input logic [5:0] dp, input logic blz);
    logic [41:0] es;
    logic [5:0]  ed;
    load       = ld;
    value      = v;
    blink_mask = m;
    dp_in      = dp;
    blank_lz   = blz;
    model_out(m_val, m_mask, m_dp, m_phase, blz, es, ed);
    exp_q.push_back(es);
    exp_dp_q.push_back(ed);
    if (ld) begin
      m_val = v; m_mask = m; m_dp = dp; m_cnt = 0; m_phase = 1'b1;
    end else if (m_cnt == BD - 1) begin
      m_cnt = 0; m_phase = ~m_phase;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    check("sb_seg", 64'(seg_n), 64'(exp_q.pop_front()));
    check("sb_dp", 64'(dp_n), 64'(exp_dp_q.pop_front()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  dp_exp;
    logic [23:0] rv;
    int          guard;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_seg", 64'(seg_n), 64'({42{1'b1}}));
    check("reset_dp", 64'(dp_n), 64'(6'h3F));

    load = 1'b1; value = 24'hABCDEF; blink_mask = 6'h3F; dp_in = 6'h3F;
    @(posedge clk);
    #1;
    check("reset_load_seg", 64'(seg_n), 64'({42{1'b1}}));
    load = 1'b0;
    #2 rst = 1'b0;

    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b1);
    check_digit("post_rst_d0", 0, 7'h40);
    check_digit("post_rst_d1", 1, 7'h7F);

    step(1'b1, 24'h0012AB, 6'h0, 6'h0, 1'b1);
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b1);
    check_digit("lz_d5", 5, 7'h7F);
    check_digit("lz_d4", 4, 7'h7F);
    check_digit("lz_d3", 3, 7'h79);
    check_digit("lz_d2", 2, 7'h24);
    check_digit("lz_d1", 1, 7'h08);
    check_digit("lz_d0", 0, 7'h03);

    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    check_digit("nolz_d5", 5, 7'h40);
    check_digit("nolz_d4", 4, 7'h40);
    check_digit("nolz_d3", 3, 7'h79);
    check_digit("nolz_d2", 2, 7'h24);
    check_digit("nolz_d1", 1, 7'h08);
    check_digit("nolz_d0", 0, 7'h03);

    step(1'b1, 24'h000008, 6'h01, 6'h0, 1'b0);
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
      check_digit("blink_d0", 0, ((j / 4) % 2 == 0) ? 7'h00 : 7'h7F);
      check_digit("blink_d1_steady", 1, 7'h40);
    end

    guard = 0;
    while (m_phase == 1'b1 && guard < 2 * BD) begin
      step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
      guard++;
    end
    step(1'b1, 24'h000008, 6'h01, 6'h0, 1'b0);
    check_digit("midblink_pre_d0", 0, 7'h7F);
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
      check_digit("midblink_shown_d0", 0, 7'h00);
    end
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    check_digit("midblink_off_d0", 0, 7'h7F);

    for (int j = 0; j < 7; j++) begin
      step(1'b1, 24'h000008, 6'h01, 6'h0, 1'b0);
      if (j > 0) check_digit("held_load_d0", 0, 7'h00);
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
      check_digit("after_held_d0", 0, 7'h00);
    end
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    check_digit("after_held_off_d0", 0, 7'h7F);

`ifdef HEX_DISP_DP_EN
    dp_exp = 6'b111101;
`else
    dp_exp = 6'b111111;
`endif
    step(1'b1, 24'h000010, 6'h0, 6'h02, 1'b1);
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b1);
    check("dp_on", 64'(dp_n), 64'(dp_exp));
    step(1'b1, 24'h000000, 6'h0, 6'h02, 1'b1);
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b1);
    check("dp_lz_blank", 64'(dp_n[1]), 64'(1'b1));
    check_digit("dp_lz_d1", 1, 7'h7F);

    step(1'b1, 24'h0012AB, 6'h3F, 6'h3F, 1'b0);
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", 64'(seg_n), 64'({42{1'b1}}));
    check("async_rst_dp", 64'(dp_n), 64'(6'h3F));
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_seg", 64'(seg_n), 64'({42{1'b1}}));
    #2 rst = 1'b0;
    step(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    check_digit("rst2_d5", 5, 7'h40);

    for (int j = 0; j < 60; j++) begin
      rv = 24'($urandom_range(0, 255)) << (4 * $urandom_range(0, 4));
      step(($urandom_range(0, 3) == 0), rv, 6'($urandom_range(0, 63)),
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
